// File: rtl/bayesian_class_scheduler_if.sv
// Request/result and Bayesian IMC core handshake bundle for the class scheduler.
// master = scheduler side, slave = requester/core side.
interface bayesian_class_scheduler_if;
  logic       req_start;
  logic [7:0] req_data;
  logic       core_start;
  logic [7:0] core_data;
  logic [1:0] core_weight_select;
  logic [3:0] core_mean;
  logic [3:0] core_conf;
  logic       core_done;
  logic       busy;
  logic       result_valid;
  logic [1:0] class_id;
  logic [3:0] class_mean;
  logic [3:0] class_conf;
  logic       abstain;
  logic       timeout_err;

  modport master (
    input  req_start, req_data, core_mean, core_conf, core_done,
    output core_start, core_data, core_weight_select, busy, result_valid,
           class_id, class_mean, class_conf, abstain, timeout_err
  );

  modport slave (
    output req_start, req_data, core_mean, core_conf, core_done,
    input  core_start, core_data, core_weight_select, busy, result_valid,
           class_id, class_mean, class_conf, abstain, timeout_err
  );
endinterface

// File: rtl/bayesian_class_scheduler.sv
// Sweeps NUM_CLASSES weight words through the Bayesian IMC core and reports the best class.
// Latency 2 + sum(D_k+3) cycles; req_start is dropped while busy, each core wait bounded by TIMEOUT_CYC.
module bayesian_class_scheduler #(
  parameter int NUM_CLASSES = 4,
  parameter int CONF_THRESH = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                        clk,
  input logic                        rst,
  bayesian_class_scheduler_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DECIDE, OUTPUT} state_t;

  localparam logic [1:0] LAST_IDX  = 2'(NUM_CLASSES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] THRESH    = 4'(CONF_THRESH);

  state_t     state, next_state;
  logic [1:0] idx;
  logic [7:0] wait_cnt;
  logic [7:0] query;
  logic [3:0] cand_mean, cand_conf;
  logic       best_vld;
  logic [1:0] best_id;
  logic [3:0] best_mean, best_conf;
  logic       timeout_err;
  logic [1:0] class_id;
  logic [3:0] class_mean, class_conf;
  logic       abstain;
  logic       wait_expired;
  logic       cand_wins;

  // Expiry is judged on the cycle the counter would reach TIMEOUT_CYC, so
  // WAIT lasts exactly TIMEOUT_CYC cycles and a done in the last one still wins.
  assign wait_expired = (wait_cnt >= WAIT_LAST);
  assign cand_wins    = !best_vld || (cand_mean > best_mean) ||
                        ((cand_mean == best_mean) && (cand_conf > best_conf));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req_start) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT: begin
        if (bus.core_done)      next_state = CAPTURE;
        else if (wait_expired)  next_state = DECIDE;
      end
      CAPTURE: next_state = (idx == LAST_IDX) ? DECIDE : ISSUE;
      DECIDE:  next_state = OUTPUT;
      OUTPUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      wait_cnt    <= '0;
      query       <= '0;
      cand_mean   <= '0;
      cand_conf   <= '0;
      best_vld    <= 1'b0;
      best_id     <= '0;
      best_mean   <= '0;
      best_conf   <= '0;
      timeout_err <= 1'b0;
      class_id    <= '0;
      class_mean  <= '0;
      class_conf  <= '0;
      abstain     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_start) begin
            query       <= bus.req_data;
            idx         <= '0;
            best_vld    <= 1'b0;
            best_id     <= '0;
            best_mean   <= '0;
            best_conf   <= '0;
            timeout_err <= 1'b0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
          if (bus.core_done) begin
            cand_mean <= bus.core_mean;
            cand_conf <= bus.core_conf;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
          end
        end
        CAPTURE: begin
          if (cand_wins) begin
            best_id   <= idx;
            best_mean <= cand_mean;
            best_conf <= cand_conf;
          end
          best_vld <= 1'b1;
          if (idx != LAST_IDX) idx <= idx + 2'd1;
        end
        // Decision registers load here so they change exactly with result_valid.
        DECIDE: begin
          class_id   <= best_id;
          class_mean <= best_mean;
          class_conf <= best_conf;
          abstain    <= timeout_err || (best_conf < THRESH);
        end
        default: ;
      endcase
    end
  end

  assign bus.core_start         = (state == ISSUE);
  assign bus.core_data          = query;
  assign bus.core_weight_select = idx;
  assign bus.busy               = (state != IDLE);
  assign bus.result_valid       = (state == OUTPUT);
  assign bus.class_id           = class_id;
  assign bus.class_mean         = class_mean;
  assign bus.class_conf         = class_conf;
  assign bus.abstain            = abstain;
  assign bus.timeout_err        = timeout_err;

endmodule

// File: tb/tb_bayesian_class_scheduler.sv
// Bench for bayesian_class_scheduler: behavioural core responder plus a sweep-level reference model.
module tb_bayesian_class_scheduler;
  localparam int NC = 4;
  localparam int TH = 8;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bayesian_class_scheduler_if ifc();

  bayesian_class_scheduler #(.NUM_CLASSES(NC), .CONF_THRESH(TH), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Core behaviour per class: mean, confidence, and reply delay (-1 = never replies).
  int mean_tab[4];
  int conf_tab[4];
  int dly_tab[4];
  logic stray_req = 1'b0;

  // Sweep observations.
  int obs_lat, obs_starts;
  int obs_sel[8];
  int obs_issue[8];
  bit obs_data_ok, obs_busy_ok;

  // Reference results.
  int exp_id, exp_mean, exp_conf, exp_lat, exp_starts;
  bit exp_ab, exp_to;

  int dmean[4][4] = '{'{3,7,5,2}, '{6,6,4,1}, '{6,6,4,1}, '{2,7,3,1}};
  int dconf[4][4] = '{'{12,12,15,9}, '{9,13,15,15}, '{13,13,15,15}, '{15,4,15,15}};
  int did[4]      = '{1, 1, 0, 1};
  bit dab[4]      = '{1'b0, 1'b0, 1'b0, 1'b1};

  // Core responder: done arrives dly+1 cycles after the core_start cycle.
  initial begin
    int k;
    ifc.core_done = 1'b0;
    ifc.core_mean = '0;
    ifc.core_conf = '0;
    forever begin
      @(posedge clk); #1;
      ifc.core_mean = 4'($urandom);
      ifc.core_conf = 4'($urandom);
      if (ifc.core_start === 1'b1 && !rst) begin
        k = int'(ifc.core_weight_select);
        if (dly_tab[k] >= 0) begin
          repeat (dly_tab[k] + 1) @(posedge clk);
          #1;
          ifc.core_done = 1'b1;
          ifc.core_mean = 4'(mean_tab[k]);
          ifc.core_conf = 4'(conf_tab[k]);
          @(posedge clk); #1;
          ifc.core_done = 1'b0;
        end
      end else if (stray_req) begin
        ifc.core_done = 1'b1;
        @(posedge clk); #1;
        ifc.core_done = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Winner = max by (mean, conf) in class order, strict improvement only; sweep stops at a timeout.
  task automatic model();
    int bm, bc, bi;
    bit have;
    bm = 0; bc = 0; bi = 0; have = 1'b0;
    exp_to = 1'b0; exp_lat = 0; exp_starts = 0;
    for (int k = 0; k < NC; k++) begin
      exp_starts++;
      exp_lat += 1;
      if (dly_tab[k] < 0 || dly_tab[k] >= TO) begin
        exp_lat += TO;
        exp_to = 1'b1;
        break;
      end
      exp_lat += dly_tab[k] + 2;
      if (!have || mean_tab[k] > bm || (mean_tab[k] == bm && conf_tab[k] > bc)) begin
        bi = k; bm = mean_tab[k]; bc = conf_tab[k];
      end
      have = 1'b1;
    end
    exp_lat += 2;
    exp_id = bi; exp_mean = bm; exp_conf = bc;
    exp_ab = exp_to || (bc < TH);
  endtask

  // Launch one sweep from IDLE and observe until result_valid; obs_lat counts cycles after the req_start cycle.
  task automatic run_sweep(input logic [7:0] q, input int poke_at);
    int cyc;
    obs_lat = -1; obs_starts = 0; obs_data_ok = 1'b1; obs_busy_ok = 1'b1;
    @(posedge clk); #1;
    ifc.req_data  = q;
    ifc.req_start = 1'b1;
    @(posedge clk); #1;
    ifc.req_start = 1'b0;
    ifc.req_data  = ~q;
    cyc = 1;
    while (obs_lat < 0 && cyc < 600) begin
      if (ifc.core_start === 1'b1) begin
        if (obs_starts < 8) begin
          obs_sel[obs_starts]   = int'(ifc.core_weight_select);
          obs_issue[obs_starts] = cyc;
        end
        obs_starts++;
      end
      if (ifc.core_data !== q) obs_data_ok = 1'b0;
      if (ifc.busy !== 1'b1) obs_busy_ok = 1'b0;
      if (ifc.result_valid === 1'b1) obs_lat = cyc;
      else begin
        if (cyc == poke_at) begin
          ifc.req_start = 1'b1;
          ifc.req_data  = q ^ 8'h5A;
        end else begin
          ifc.req_start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    ifc.req_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.req_start = 1'b1;
    ifc.req_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ifc.core_start, ifc.busy, ifc.result_valid, ifc.abstain, ifc.timeout_err, ifc.class_id,
         ifc.class_mean, ifc.class_conf, ifc.core_weight_select, ifc.core_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got start=%b busy=%b rv=%b ab=%b to=%b id=%0d m=%0d c=%0d sel=%0d data=%h want all 0",
               ifc.core_start, ifc.busy, ifc.result_valid, ifc.abstain, ifc.timeout_err, ifc.class_id,
               ifc.class_mean, ifc.class_conf, ifc.core_weight_select, ifc.core_data);
    end
    ifc.req_start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] q;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) begin
        mean_tab[k] = dmean[t][k];
        conf_tab[k] = dconf[t][k];
        dly_tab[k]  = $urandom_range(0, 3);
      end
      model();
      q = 8'($urandom);
      run_sweep(q, -1);
      n_cmp++; if (ifc.class_id !== 2'(did[t])) begin n_bad++; $display("FAIL directed%0d class_id: got %0d want %0d", t, ifc.class_id, did[t]); end
      n_cmp++; if (ifc.class_mean !== 4'(exp_mean)) begin n_bad++; $display("FAIL directed%0d class_mean: got %0d want %0d", t, ifc.class_mean, exp_mean); end
      n_cmp++; if (ifc.class_conf !== 4'(exp_conf)) begin n_bad++; $display("FAIL directed%0d class_conf: got %0d want %0d", t, ifc.class_conf, exp_conf); end
      n_cmp++; if (ifc.abstain !== dab[t]) begin n_bad++; $display("FAIL directed%0d abstain: got %b want %b", t, ifc.abstain, dab[t]); end
      n_cmp++; if (ifc.timeout_err !== 1'b0) begin n_bad++; $display("FAIL directed%0d timeout_err: got %b want 0", t, ifc.timeout_err); end
      n_cmp++; if (obs_lat !== exp_lat) begin n_bad++; $display("FAIL directed%0d latency: got %0d want %0d", t, obs_lat, exp_lat); end
    end
    // Decision outputs must hold after the result pulse.
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ifc.class_id !== 2'(did[3]) || ifc.abstain !== 1'b1 || ifc.result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL result_hold: got id=%0d ab=%b rv=%b want id=%0d ab=1 rv=0", ifc.class_id, ifc.abstain, ifc.result_valid, did[3]);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      mean_tab[k] = $urandom_range(0, 15);
      conf_tab[k] = $urandom_range(0, 15);
      dly_tab[k]  = 0;
    end
    model();
    run_sweep(8'h3C, -1);
    n_cmp++; if (obs_lat + 1 !== 1 + NC * 3 + 2) begin n_bad++; $display("FAIL d0_latency_cycles: got %0d want %0d", obs_lat + 1, 1 + NC * 3 + 2); end
    n_cmp++; if (obs_starts !== 4) begin n_bad++; $display("FAIL d0_start_count: got %0d want 4", obs_starts); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (obs_sel[k] !== k) begin n_bad++; $display("FAIL d0_weight_select%0d: got %0d want %0d", k, obs_sel[k], k); end
    end
    n_cmp++; if (ifc.class_id !== 2'(exp_id)) begin n_bad++; $display("FAIL d0_class_id: got %0d want %0d", ifc.class_id, exp_id); end
    // Next request in the cycle straight after result_valid.
    mean_tab[2] = 15; conf_tab[2] = 15;
    model();
    run_sweep(8'hC3, -1);
    n_cmp++; if (obs_data_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_core_data: got unstable want 8'hc3 throughout"); end
    n_cmp++; if (ifc.class_id !== 2'(exp_id) || ifc.class_mean !== 4'(exp_mean)) begin n_bad++; $display("FAIL b2b_result: got id=%0d m=%0d want id=%0d m=%0d", ifc.class_id, ifc.class_mean, exp_id, exp_mean); end
    n_cmp++; if (obs_lat !== exp_lat) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", obs_lat, exp_lat); end
  endtask

  task automatic test_timeout();
    mean_tab = '{5, 9, 3, 15}; conf_tab = '{10, 11, 15, 15}; dly_tab = '{1, 2, -1, 0};
    model();
    run_sweep(8'h77, -1);
    n_cmp++; if (ifc.timeout_err !== 1'b1 || ifc.abstain !== 1'b1) begin n_bad++; $display("FAIL to_flags: got to=%b ab=%b want to=1 ab=1", ifc.timeout_err, ifc.abstain); end
    n_cmp++; if (ifc.class_id !== 2'd1 || ifc.class_mean !== 4'd9 || ifc.class_conf !== 4'd11) begin n_bad++; $display("FAIL to_best: got id=%0d m=%0d c=%0d want id=1 m=9 c=11", ifc.class_id, ifc.class_mean, ifc.class_conf); end
    n_cmp++; if (obs_starts !== 3) begin n_bad++; $display("FAIL to_start_count: got %0d want 3", obs_starts); end
    n_cmp++; if (obs_lat - obs_issue[2] !== TO + 2) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", obs_lat - obs_issue[2], TO + 2); end
    // Done in the last allowed wait cycle is a normal completion; also clears the sticky flag.
    dly_tab = '{0, 0, TO - 1, 0};
    model();
    run_sweep(8'h12, -1);
    n_cmp++; if (ifc.timeout_err !== 1'b0) begin n_bad++; $display("FAIL edge_done_timeout_err: got %b want 0", ifc.timeout_err); end
    n_cmp++; if (ifc.class_id !== 2'(exp_id) || ifc.abstain !== exp_ab) begin n_bad++; $display("FAIL edge_done_result: got id=%0d ab=%b want id=%0d ab=%b", ifc.class_id, ifc.abstain, exp_id, exp_ab); end
    n_cmp++; if (obs_lat !== exp_lat) begin n_bad++; $display("FAIL edge_done_latency: got %0d want %0d", obs_lat, exp_lat); end
    // Class 0 answers one cycle too late: nothing captured, late done ignored.
    dly_tab = '{TO, 0, 0, 0};
    model();
    run_sweep(8'h99, -1);
    n_cmp++; if ({ifc.class_id, ifc.class_mean, ifc.class_conf} !== '0 || ifc.abstain !== 1'b1 || ifc.timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL to_none: got id=%0d m=%0d c=%0d ab=%b to=%b want 0/0/0 ab=1 to=1", ifc.class_id, ifc.class_mean, ifc.class_conf, ifc.abstain, ifc.timeout_err); end
    n_cmp++; if (obs_lat !== exp_lat) begin n_bad++; $display("FAIL to_none_latency: got %0d want %0d", obs_lat, exp_lat); end
  endtask

  task automatic test_busy_ignore();
    int extra;
    for (int k = 0; k < 4; k++) begin
      mean_tab[k] = $urandom_range(0, 15);
      conf_tab[k] = $urandom_range(0, 15);
      dly_tab[k]  = $urandom_range(0, 2);
    end
    model();
    run_sweep(8'hE1, 4);
    n_cmp++; if (obs_data_ok !== 1'b1) begin n_bad++; $display("FAIL busy_core_data: got changed want 8'he1 held"); end
    n_cmp++; if (obs_lat !== exp_lat || obs_starts !== 4) begin n_bad++; $display("FAIL busy_restart: got lat=%0d starts=%0d want lat=%0d starts=4", obs_lat, obs_starts, exp_lat); end
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ifc.busy !== 1'b0 || ifc.core_start !== 1'b0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL busy_queued: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_random();
    logic [7:0] q;
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 4; k++) begin
        mean_tab[k] = $urandom_range(0, 15);
        conf_tab[k] = $urandom_range(0, 15);
        dly_tab[k]  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      end
      model();
      q = 8'($urandom);
      run_sweep(q, -1);
      n_cmp++;
      if (obs_lat !== exp_lat || obs_starts !== exp_starts || ifc.class_id !== 2'(exp_id) ||
          ifc.class_mean !== 4'(exp_mean) || ifc.class_conf !== 4'(exp_conf) || ifc.abstain !== exp_ab ||
          ifc.timeout_err !== exp_to || obs_data_ok !== 1'b1 || obs_busy_ok !== 1'b1) begin
        n_bad++;
        $display("FAIL random%0d: got lat=%0d st=%0d id=%0d m=%0d c=%0d ab=%b to=%b dok=%b bok=%b want lat=%0d st=%0d id=%0d m=%0d c=%0d ab=%b to=%b dok=1 bok=1",
                 it, obs_lat, obs_starts, ifc.class_id, ifc.class_mean, ifc.class_conf, ifc.abstain, ifc.timeout_err,
                 obs_data_ok, obs_busy_ok, exp_lat, exp_starts, exp_id, exp_mean, exp_conf, exp_ab, exp_to);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int rv_seen, busy_seen;
    mean_tab = '{1, 9, 1, 1}; conf_tab = '{15, 15, 15, 15}; dly_tab = '{0, 1, 0, 0};
    run_sweep(8'h6B, -1);
    n_cmp++; if (ifc.class_id !== 2'd1) begin n_bad++; $display("FAIL pre_reset_class_id: got %0d want 1", ifc.class_id); end
    dly_tab = '{-1, -1, -1, -1};
    @(posedge clk); #1;
    ifc.req_data = 8'hF0; ifc.req_start = 1'b1;
    @(posedge clk); #1;
    ifc.req_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({ifc.core_start, ifc.busy, ifc.result_valid, ifc.abstain, ifc.timeout_err, ifc.class_id,
         ifc.class_mean, ifc.class_conf, ifc.core_weight_select, ifc.core_data} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got busy=%b id=%0d m=%0d c=%0d sel=%0d data=%h want all 0",
               ifc.busy, ifc.class_id, ifc.class_mean, ifc.class_conf, ifc.core_weight_select, ifc.core_data);
    end
    stray_req = 1'b1;
    rv_seen = 0; busy_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ifc.result_valid !== 1'b0) rv_seen++;
      if (ifc.busy !== 1'b0) busy_seen++;
    end
    stray_req = 1'b0;
    n_cmp++; if (rv_seen !== 0) begin n_bad++; $display("FAIL mid_reset_result_valid: got %0d pulses want 0", rv_seen); end
    n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL mid_reset_stray_done: got %0d busy cycles want 0", busy_seen); end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    ifc.req_start = 1'b0;
    ifc.req_data  = '0;
    mean_tab = '{0, 0, 0, 0}; conf_tab = '{0, 0, 0, 0}; dly_tab = '{0, 0, 0, 0};
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_busy_ignore();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
